// File: rtl/register_file_scoreboard.sv
// 16-entry register file with write-to-read bypass and a per-register pending-write scoreboard.
// Register 0 is optionally hard-wired to zero and excluded from the scoreboard.
`timescale 1ns/1ps
module register_file_scoreboard #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            SrcReg1,
    input  logic [3:0]            SrcReg2,
    output logic [DATA_WIDTH-1:0] SrcData1,
    output logic [DATA_WIDTH-1:0] SrcData2,
    input  logic [3:0]            DstReg,
    input  logic                  WriteReg,
    input  logic [DATA_WIDTH-1:0] DstData,
    input  logic                  ReserveReg,
    input  logic [3:0]            ReserveId,
    output logic                  Busy1,
    output logic                  Busy2,
    output logic [15:0]           BusyVec
);

    logic [DATA_WIDTH-1:0] regs [16];
    logic [15:0]           busyQ;
    logic [15:0]           wordLine;
    logic [15:0]           setMask;
    logic                  hit1;
    logic                  hit2;

    always_comb begin
        wordLine = '0;
        setMask  = '0;
        if (WriteReg) begin
            wordLine[DstReg] = 1'b1;
        end
        if (ReserveReg) begin
            setMask[ReserveId] = 1'b1;
        end
        // Masking bit 0 here discards R0 writes and keeps its busy bit clear.
        if (ZERO_REG) begin
            wordLine[0] = 1'b0;
            setMask[0]  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
            busyQ <= '0;
        end else begin
            for (int unsigned i = 0; i < 16; i++) begin
                if (wordLine[i]) begin
                    regs[i] <= DstData;
                end
            end
            // Set after clear so a same-cycle reserve of the written id stays pending.
            busyQ <= (busyQ & ~wordLine) | setMask;
        end
    end

    assign hit1 = WriteReg && (DstReg == SrcReg1);
    assign hit2 = WriteReg && (DstReg == SrcReg2);

    always_comb begin
        SrcData1 = regs[SrcReg1];
        if (hit1) begin
            SrcData1 = DstData;
        end
        if (ZERO_REG && (SrcReg1 == 4'd0)) begin
            SrcData1 = '0;
        end
    end

    always_comb begin
        SrcData2 = regs[SrcReg2];
        if (hit2) begin
            SrcData2 = DstData;
        end
        if (ZERO_REG && (SrcReg2 == 4'd0)) begin
            SrcData2 = '0;
        end
    end

    assign Busy1   = busyQ[SrcReg1] & ~hit1;
    assign Busy2   = busyQ[SrcReg2] & ~hit2;
    assign BusyVec = busyQ;

endmodule
